// File: rtl/time_keeper.sv
// time_keeper: hh:mm:ss real-time clock with prescaler, load, per-field adjust and 12/24h display.
// Define TIME_KEEPER_ALARM_EN to build the alarm state machine; otherwise ALARM is tied low.
module time_keeper #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int DIV_W         = 27
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        RUN,
    input  logic        LOAD,
    input  logic [16:0] LOAD_TIME,
    input  logic [2:0]  INC,
    input  logic [2:0]  DEC,
    input  logic        MODE_12,
    input  logic [10:0] ALARM_TIME,
    input  logic        ALARM_ARM,
    input  logic        ALARM_ACK,
    output logic [16:0] CURR_TIME,
    output logic [4:0]  DISP_HOUR,
    output logic        PM,
    output logic        SEC_TICK,
    output logic        LOAD_ERR,
    output logic        ALARM
);
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0] hh_q, hh_d, th;
    logic [5:0] mm_q, mm_d, ss_q, ss_d, tm, ts;
    logic pend_q, pend_d, stick_q, stick_d, lerr_q, lerr_d;
    logic wrap, adj, ld_ok, commit;

    function automatic logic [5:0] step(input logic [5:0] v, input logic [5:0] top, input logic up, input logic dn);
        return (up && !dn) ? ((v == top) ? 6'd0 : v + 6'd1) :
               (dn && !up) ? ((v == 6'd0) ? top : v - 6'd1) : v;
    endfunction

    assign wrap  = RUN && (div_q == DIV_W'(TICKS_PER_SEC - 1));
    assign adj   = |{INC, DEC};
    assign ld_ok = (LOAD_TIME[16:12] <= 5'd23) && (LOAD_TIME[11:6] <= 6'd59) && (LOAD_TIME[5:0] <= 6'd59);
    assign ts    = (ss_q == 6'd59) ? 6'd0 : ss_q + 6'd1;
    assign tm    = (ss_q != 6'd59) ? mm_q : (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
    assign th    = (ss_q != 6'd59 || mm_q != 6'd59) ? hh_q : (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;

    // A tick landing on an adjust cycle is owed and paid on the next free cycle.
    always_comb begin
        div_d   = RUN ? (wrap ? '0 : div_q + DIV_W'(1)) : div_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        pend_d  = pend_q;
        lerr_d  = 1'b0;
        commit  = 1'b0;
        if (LOAD && ld_ok) begin
            {hh_d, mm_d, ss_d} = LOAD_TIME;
            div_d  = '0;
            pend_d = 1'b0;
        end else if (LOAD) begin
            lerr_d = 1'b1;
            commit = wrap;
        end else if (adj) begin
            hh_d   = 5'(step({1'b0, hh_q}, 6'd23, INC[2], DEC[2]));
            mm_d   = step(mm_q, 6'd59, INC[1], DEC[1]);
            ss_d   = step(ss_q, 6'd59, INC[0], DEC[0]);
            div_d  = '0;
            pend_d = pend_q | wrap;
        end else begin
            commit = wrap | pend_q;
            pend_d = wrap & pend_q;
        end
        if (commit) {hh_d, mm_d, ss_d} = {th, tm, ts};
        stick_d = commit;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_q   <= '0;
            hh_q    <= '0;
            mm_q    <= '0;
            ss_q    <= '0;
            pend_q  <= 1'b0;
            stick_q <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            pend_q  <= pend_d;
            stick_q <= stick_d;
            lerr_q  <= lerr_d;
        end
    end

    assign CURR_TIME = {hh_q, mm_q, ss_q};
    assign SEC_TICK  = stick_q;
    assign LOAD_ERR  = lerr_q;
    assign DISP_HOUR = !MODE_12 ? hh_q : (hh_q == 5'd0) ? 5'd12 : (hh_q > 5'd12) ? hh_q - 5'd12 : hh_q;
    assign PM        = MODE_12 && (hh_q >= 5'd12);

`ifdef TIME_KEEPER_ALARM_EN
    typedef enum logic [1:0] {DISARMED, ARMED, RINGING, WAIT} state_t;
    state_t state_q, state_d;
    logic [5:0] rc_q, rc_d;
    logic alarm_q, hit_new, hit_cur;

    assign hit_new = commit && ({th, tm} == ALARM_TIME) && (ts == 6'd0);
    assign hit_cur = {hh_q, mm_q} == ALARM_TIME;

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        case (state_q)
            DISARMED: state_d = ALARM_ARM ? ARMED : DISARMED;
            ARMED: begin
                state_d = !ALARM_ARM ? DISARMED : hit_new ? RINGING : ARMED;
                rc_d    = 6'd0;
            end
            RINGING: begin
                rc_d    = commit ? rc_q + 6'd1 : rc_q;
                state_d = (ALARM_ACK || !ALARM_ARM || (commit && rc_q == 6'd59)) ? WAIT : RINGING;
            end
            default: state_d = !ALARM_ARM ? DISARMED : !hit_cur ? ARMED : WAIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= DISARMED;
            rc_q    <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            alarm_q <= (state_d == RINGING);
        end
    end

    assign ALARM = alarm_q;
`else
    logic unused_alarm;
    assign unused_alarm = ^{ALARM_TIME, ALARM_ARM, ALARM_ACK};
    assign ALARM = 1'b0;
`endif
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed scenarios plus randomized traffic against a seconds-of-day reference model.
module tb_time_keeper;
    localparam int T = 4;
`ifdef TIME_KEEPER_ALARM_EN
    localparam int AEN = 1;
`else
    localparam int AEN = 0;
`endif

    logic        CLK = 0, RESET_N = 0, RUN = 0, LOAD = 0, MODE_12 = 0, ALARM_ARM = 0, ALARM_ACK = 0;
    logic [16:0] LOAD_TIME = 0;
    logic [2:0]  INC = 0, DEC = 0;
    logic [10:0] ALARM_TIME = 0;
    logic [16:0] CURR_TIME;
    logic [4:0]  DISP_HOUR;
    logic        PM, SEC_TICK, LOAD_ERR, ALARM;

    int checks = 0, errors = 0;

    time_keeper #(.TICKS_PER_SEC(T), .DIV_W(3)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN), .LOAD(LOAD), .LOAD_TIME(LOAD_TIME),
        .INC(INC), .DEC(DEC), .MODE_12(MODE_12), .ALARM_TIME(ALARM_TIME),
        .ALARM_ARM(ALARM_ARM), .ALARM_ACK(ALARM_ACK), .CURR_TIME(CURR_TIME),
        .DISP_HOUR(DISP_HOUR), .PM(PM), .SEC_TICK(SEC_TICK), .LOAD_ERR(LOAD_ERR), .ALARM(ALARM)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pack(input int h, input int m, input int s);
        return h * 4096 + m * 64 + s;
    endfunction

    // Reference model: time as seconds of day, owed ticks as a plain count.
    int m_secs, m_pc, m_owed, m_ast, m_rings, m_old, h, m, s, lh, lm, ls;
    bit m_st, m_le, tick, commit;

    always @(posedge CLK) begin
        if (!RESET_N) begin
            m_secs = 0; m_pc = 0; m_owed = 0; m_ast = 0; m_rings = 0; m_st = 0; m_le = 0;
        end else begin
            m_old  = m_secs;
            tick   = RUN && m_pc == T - 1;
            m_pc   = RUN ? (m_pc + 1) % T : m_pc;
            commit = 0;
            m_le   = 0;
            lh = int'(LOAD_TIME[16:12]); lm = int'(LOAD_TIME[11:6]); ls = int'(LOAD_TIME[5:0]);
            if (LOAD && lh < 24 && lm < 60 && ls < 60) begin
                m_secs = lh * 3600 + lm * 60 + ls;
                m_pc = 0; m_owed = 0;
            end else if (LOAD) begin
                m_le = 1;
                commit = tick;
            end else if (INC != 0 || DEC != 0) begin
                h = m_secs / 3600; m = (m_secs / 60) % 60; s = m_secs % 60;
                h = (h + int'(INC[2]) - int'(DEC[2]) + 24) % 24;
                m = (m + int'(INC[1]) - int'(DEC[1]) + 60) % 60;
                s = (s + int'(INC[0]) - int'(DEC[0]) + 60) % 60;
                m_secs = h * 3600 + m * 60 + s;
                m_pc = 0;
                m_owed += int'(tick);
            end else begin
                commit = tick || m_owed > 0;
                m_owed = m_owed + int'(tick) - int'(commit);
            end
            if (commit) m_secs = (m_secs + 1) % 86400;
            m_st = commit;
            case (m_ast)
                0: if (ALARM_ARM) m_ast = 1;
                1: if (!ALARM_ARM) m_ast = 0;
                   else if (commit && m_secs / 60 == int'(ALARM_TIME[10:6]) * 60 + int'(ALARM_TIME[5:0]) && m_secs % 60 == 0) begin
                       m_ast = 2; m_rings = 0;
                   end
                2: if (ALARM_ACK || !ALARM_ARM) m_ast = 3;
                   else if (commit) begin
                       m_rings++;
                       if (m_rings == 60) m_ast = 3;
                   end
                default: if (!ALARM_ARM) m_ast = 0;
                   else if (m_old / 60 != int'(ALARM_TIME[10:6]) * 60 + int'(ALARM_TIME[5:0])) m_ast = 1;
            endcase
        end
        #1;
        if (RESET_N) begin
            h = m_secs / 3600;
            chk("curr_time", int'(CURR_TIME), pack(h, (m_secs / 60) % 60, m_secs % 60));
            chk("sec_tick", int'(SEC_TICK), int'(m_st));
            chk("load_err", int'(LOAD_ERR), int'(m_le));
            chk("alarm", int'(ALARM), (AEN == 1 && m_ast == 2) ? 1 : 0);
            chk("disp_hour", int'(DISP_HOUR), MODE_12 ? ((h % 12 == 0) ? 12 : h % 12) : h);
            chk("pm", int'(PM), (MODE_12 && h >= 12) ? 1 : 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load(input int t);
        LOAD = 1; LOAD_TIME = 17'(t);
        cyc(1);
        LOAD = 0;
    endtask

    initial begin
        cyc(2);
        RESET_N = 1;
        chk("reset_time", int'(CURR_TIME), 0);
        chk("reset_alarm", int'(ALARM), 0);
        RUN = 1;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            chk("tick_pulse", int'(SEC_TICK), (i % 4 == 0) ? 1 : 0);
        end
        chk("twelve_cycles", int'(CURR_TIME), 3);

        MODE_12 = 1;
        load(pack(23, 59, 59));
        chk("load_2359", int'(CURR_TIME), pack(23, 59, 59));
        chk("disp_23", int'(DISP_HOUR), 11);
        chk("pm_23", int'(PM), 1);
        cyc(4);
        chk("midnight", int'(CURR_TIME), 0);
        chk("midnight_tick", int'(SEC_TICK), 1);
        chk("disp_0", int'(DISP_HOUR), 12);
        chk("pm_0", int'(PM), 0);
        MODE_12 = 0;

        RUN = 0;
        load(pack(24, 0, 0));
        chk("bad_load_err", int'(LOAD_ERR), 1);
        chk("bad_load_time", int'(CURR_TIME), 0);
        cyc(1);
        chk("bad_load_once", int'(LOAD_ERR), 0);

        load(pack(10, 0, 59));
        DEC = 3'b101; INC = 3'b011;
        cyc(1);
        DEC = 0; INC = 0;
        chk("adjust", int'(CURR_TIME), pack(9, 1, 59));

        RUN = 1;
        load(5);
        cyc(3);
        INC = 3'b001;
        cyc(1);
        INC = 0;
        chk("inc_on_wrap", int'(CURR_TIME), 6);
        chk("inc_no_tick", int'(SEC_TICK), 0);
        cyc(1);
        chk("deferred_tick", int'(CURR_TIME), 7);
        chk("deferred_pulse", int'(SEC_TICK), 1);

        #2 RESET_N = 0;
        #1 chk("async_reset", int'(CURR_TIME), 0);
        cyc(1);
        RESET_N = 1;

        ALARM_TIME = 11'(7 * 64 + 30); ALARM_ARM = 1;
        load(pack(7, 29, 59));
        cyc(4);
        chk("ring", int'(ALARM), AEN);
        chk("ring_time", int'(CURR_TIME), pack(7, 30, 0));
        ALARM_ACK = 1;
        cyc(1);
        ALARM_ACK = 0;
        chk("ack_drop", int'(ALARM), 0);
        cyc(239);
        chk("wait_end_time", int'(CURR_TIME), pack(7, 31, 0));
        load(pack(7, 29, 59));
        cyc(4);
        chk("ring2", int'(ALARM), AEN);
        cyc(236);
        chk("ring2_held", int'(ALARM), AEN);
        cyc(4);
        chk("ring2_timeout", int'(ALARM), 0);
        chk("ring2_time", int'(CURR_TIME), pack(7, 31, 0));

        for (int i = 0; i < 4000; i++) begin
            cyc(1);
            if (i == 2000) RESET_N = 0;
            if (i == 2001) RESET_N = 1;
            RUN = $urandom_range(0, 9) != 0;
            LOAD = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 1) == 1)
                LOAD_TIME = 17'(pack($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(50, 59)));
            else
                LOAD_TIME = 17'($urandom);
            INC = ($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'd0;
            DEC = ($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'd0;
            MODE_12 = 1'($urandom);
            ALARM_ARM = $urandom_range(0, 49) != 0;
            ALARM_ACK = $urandom_range(0, 99) == 0;
            if ($urandom_range(0, 149) == 0) begin
                s = (m_secs + $urandom_range(0, 90)) % 86400;
                ALARM_TIME = 11'((s / 3600) * 64 + (s / 60) % 60);
            end
            if (LOAD && $urandom_range(0, 2) == 0) begin
                s = ($urandom_range(0, 1) == 1) ? int'(ALARM_TIME[10:6]) * 3600 + int'(ALARM_TIME[5:0]) * 60 - 2 : 86398;
                s = (s + 86400) % 86400;
                LOAD_TIME = 17'(pack(s / 3600, (s / 60) % 60, s % 60));
            end
        end
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/time_keeper.md
# time_keeper

Parametrised real-time clock core for the clock datapath, successor to the fixed-format time handler. It owns the hh:mm:ss registers, advances them from a programmable prescaler, and accepts bulk loads and per-field increment/decrement from the button front end. It also provides 12/24-hour display conversion and an optional alarm state machine. Its output feeds the output display driver.

## Interface
Parameters:
- TICKS_PER_SEC, default 100000000: CLK cycles per second (100 MHz); must be ≥ 2.
- DIV_W, default 27: prescaler width; must satisfy 2^DIV_W ≥ TICKS_PER_SEC.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- RUN  in  1  1 = prescaler and time advance; 0 = hold.
- LOAD  in  1  single-cycle load strobe.
- LOAD_TIME  in  17  {hh[16:12], mm[11:6], ss[5:0]}, 24-hour binary.
- INC  in  3  {hour, min, sec} increment strobes.
- DEC  in  3  {hour, min, sec} decrement strobes.
- MODE_12  in  1  1 = 12-hour display.
- ALARM_TIME  in  11  {hh[10:6], mm[5:0]}.
- ALARM_ARM  in  1  level; arms the alarm.
- ALARM_ACK  in  1  single-cycle acknowledge.
- CURR_TIME  out  17  registered time, same packing as LOAD_TIME.
- DISP_HOUR  out  5  display hour.
- PM  out  1  afternoon flag.
- SEC_TICK  out  1  one-cycle pulse on each seconds advance.
- LOAD_ERR  out  1  one-cycle pulse when a LOAD is rejected.
- ALARM  out  1  level; high while ringing.

## Operation
- **Reset (RESET_N=0):** CURR_TIME=0, prescaler=0, tick_pending=0, SEC_TICK=0, LOAD_ERR=0, ALARM=0, alarm FSM=DISARMED.
- **Prescaler:** counts 0..TICKS_PER_SEC-1 while RUN=1; holds while RUN=0. The wrap generates a tick.
- **Tick:** ss+1. Carries ss 59→0 into mm+1; mm 59→0 into hh+1; hh 23→0. 23:59:59 → 00:00:00.
- **Priority per cycle:** LOAD > INC/DEC > tick.
- **LOAD, valid (hh≤23, mm≤59, ss≤59):** CURR_TIME=LOAD_TIME, prescaler=0, tick_pending=0, and a tick in the same cycle is discarded.
- **LOAD, invalid:** CURR_TIME is unchanged; LOAD_ERR pulses; INC/DEC in that cycle are ignored; a tick in that cycle is applied normally.
- **INC/DEC:** each field is adjusted independently; several fields may change in one cycle. Each field wraps within its own range (ss/mm 0..59, hh 0..23) with no carry. INC and DEC both set on one field → that field is unchanged. An adjust sets prescaler=0.
- **Tick during a cycle with any INC/DEC bit set:** the tick is not lost. tick_pending is set and the tick is applied on the next cycle that has no LOAD and no INC/DEC.
- **Display:**
  - MODE_12=0: DISP_HOUR=hh, PM=0.
  - MODE_12=1: DISP_HOUR = 12 if hh=0; hh-12 if hh>12; hh otherwise. PM = (hh≥12).
  - Both outputs are combinational from CURR_TIME and MODE_12.
- **Alarm FSM:**
  - DISARMED → ARMED when ALARM_ARM=1.
  - ARMED → DISARMED when ALARM_ARM=0.
  - ARMED → RINGING on a committed tick whose result has hh:mm=ALARM_TIME and ss=0.
  - RINGING drives ALARM=1. It goes to WAIT on ALARM_ACK, on ALARM_ARM=0, or after 60 committed ticks.
  - WAIT → ARMED when hh:mm≠ALARM_TIME; WAIT → DISARMED if ALARM_ARM=0.
  - LOAD and INC/DEC never trigger RINGING.

## Timing
- All outputs except DISP_HOUR/PM are registered.
- Tick, LOAD, and adjust results appear on CURR_TIME one cycle after the edge where the event is sampled.
- SEC_TICK is high in the same cycle CURR_TIME shows the new second, including deferred ticks.
- Tick period is TICKS_PER_SEC cycles from a prescaler clear.
- ALARM rises in the same cycle as the matching CURR_TIME update. It falls the cycle after ALARM_ACK.
- Reset mid-operation clears everything immediately, with no wait for CLK.

## Configuration
- Macro TIME_KEEPER_ALARM_EN.
- Defined: alarm FSM and compare logic are present, as described above.
- Undefined: ALARM is tied to 0; ALARM_TIME, ALARM_ARM and ALARM_ACK are accepted but ignored; no FSM is synthesised. All other behaviour is identical.

## Test plan
Benches use TICKS_PER_SEC=4, DIV_W=3.
- **Reset, then RUN=1 for 12 cycles:** CURR_TIME=00:00:03; SEC_TICK pulses at cycles 4, 8, 12.
- **LOAD 23:59:59, RUN=1, wait 4 cycles:** CURR_TIME=00:00:00, SEC_TICK=1. Same run with MODE_12=1: DISP_HOUR=12, PM=0.
- **LOAD 24:00:00:** LOAD_ERR pulses once; CURR_TIME unchanged.
- **LOAD 10:00:59, then DEC={1,0,1} and INC={0,1,1}:** result 09:01:59. Sec field has INC and DEC both set, so it is unchanged.
- **INC[0] in the cycle the prescaler wraps, time 00:00:05:** next CURR_TIME=00:00:06 from the increment. The cycle after shows 00:00:07 with SEC_TICK=1.
- **With alarm enabled, ALARM_TIME=07:30, ARM=1, LOAD 07:29:59, RUN=1:** after 4 cycles, ALARM=1. ALARM_ACK → ALARM=0 and the FSM stays in WAIT until 07:31:00. Repeat without ACK: ALARM drops after 60 ticks.
